imem_fetch_responder: RTL
=========================

Name: imem_fetch_responder

Overview:
- Responder side of the PC-fetch interface. It consumes the PC from the fetch stage and returns the addressed instruction to decode.
- It drives the fetch stage's hlt while an instruction is not yet available, or while decode stalls.
- It fetches from a variable-latency instruction memory over a req/ack handshake and holds the last fetched word in a 1-entry line buffer.
- The fetch stage's redirect (useAlt) enters as flush and squashes wrong-path fetches.

Parameters:
AW, 16, address/PC width
DW, 16, instruction width

Ports:
clk  in  1  clock, rising edge
nRst  in  1  reset, asynchronous, active-low
pc  in  AW  current PC from fetch stage
flush  in  1  redirect this cycle (same signal as fetch-stage useAlt)
dec_stall  in  1  decode cannot accept an instruction this cycle
hlt  out  1  combinational; fetch stage holds pc while high
mem_req  out  1  memory read request, registered
mem_addr  out  AW  read address, registered, stable while mem_req=1
mem_ack  in  1  read data valid this cycle; meaningful only while mem_req=1
mem_rdata  in  DW  read data, sampled when mem_ack=1
instr  out  DW  instruction to decode, registered
instr_valid  out  1  instr is valid, registered

Behaviour:
- Reset (async, nRst=0): state=IDLE, mem_req=0, mem_addr=0, instr=0, instr_valid=0, buf_vld=0, buf_addr=0, buf_data=0.
- Reset mid-request abandons the transaction. Memory must tolerate a dropped req.
- hit = buf_vld && (buf_addr == pc), combinational.
- hlt = !flush && (!hit || dec_stall).
  - hlt must never be asserted with flush, because the fetch stage gives hlt priority over useAlt.
- States: IDLE, BUSY, DROP.
- IDLE:
  - flush=1: no request is issued. Stay IDLE.
  - !hit && !flush: next edge sets mem_req=1 and mem_addr=pc, and goes to BUSY.
  - hit: no request.
- BUSY (mem_req=1):
  - mem_ack=1 && !flush: buf_addr<=mem_addr, buf_data<=mem_rdata, buf_vld<=1, mem_req<=0, go IDLE.
  - mem_ack=1 && flush: data is discarded, buffer unchanged, mem_req<=0, go IDLE.
  - mem_ack=0 && flush: go DROP, mem_req stays 1. A request is never retracted.
  - mem_ack=0 && !flush: stay BUSY.
- DROP (mem_req=1):
  - Waits for mem_ack. Data is discarded, mem_req<=0, go IDLE.
  - A flush while in DROP has no further effect.
- Output register, each edge:
  - flush=1: instr_valid<=0, instr unchanged.
  - Else if dec_stall=1: instr and instr_valid hold.
  - Else if hit: instr<=buf_data, instr_valid<=1.
  - Else: instr_valid<=0.
- Latency, miss with memory ack at cycle N:
  - Request is visible at edge E+1 after the miss cycle.
  - Buffer is written at edge N+1.
  - hit and hlt=0 during cycle N+1.
  - instr_valid=1 from edge N+2.
  - With zero wait states (ack in the first req cycle), a miss costs 2 hlt cycles.
- Hit in steady state: hlt=0, one instruction per cycle. Each new pc only hits if it equals buf_addr; otherwise a new miss starts.
- A new miss cannot be issued until the state returns to IDLE. At most one outstanding request.
- Buffer is never invalidated except by reset. Self-modifying code is out of scope.
- Address comparison is on the full AW width, with no wrap-around special case. PC 0xFFFF→0x0000 is just a new address.

Decomposition:
- Package imem_fetch_pkg:
  - fetch_state_t enum (IDLE, BUSY, DROP)
  - AW_DEF=16, DW_DEF=16
- Optional sub-module imem_line_buf holds buf_vld/buf_addr/buf_data with a write port and a hit compare. Everything else is one module.

Test Plan:
1. Reset with pc=0x0000, then release nRst. Memory acks 0xA5A5 one cycle after req → mem_req=1, mem_addr=0x0000; hlt=1 until the buffer fills; instr=0xA5A5 with instr_valid=1 two edges after the ack.
2. pc held at 0x0010 after a fill with dec_stall=0 → no new mem_req; instr_valid stays 1 each cycle with instr=buffered data; hlt=0.
3. Miss at 0x0020 with a 3-cycle ack delay; flush=1 in the 2nd wait cycle → hlt=0 in the flush cycle; state DROP; mem_req stays 1 until ack; ack data 0xDEAD is discarded; buf_addr unchanged; instr_valid=0; the next pc (altAddress 0x0100) is fetched afterwards.
4. Hit with dec_stall=1 for 3 cycles → hlt=1; instr and instr_valid held; no mem_req; on release, the next edge emits normally.
5. flush coincident with mem_ack in BUSY → data discarded, state IDLE, mem_req=0 next edge, buffer unchanged.
6. Assert nRst=0 mid-BUSY (no ack) → mem_req, instr_valid and buf_vld drop immediately (asynchronously); after release, a fresh request is issued for the current pc.

Source files
------------

// File: rtl/imem_fetch_pkg.sv
// rtl/imem_fetch_pkg.sv - shared types and defaults for the instruction fetch responder
package imem_fetch_pkg;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/imem_line_buf.sv
// rtl/imem_line_buf.sv - single-entry instruction line buffer with hit compare
//
// Ports:
//   clk, nRst        clock, async active-low reset
//   we, waddr, wdata write port (fill from memory)
//   pc               lookup address
//   hit              buffer valid and its address equals pc (full width)
//   rdata            buffered instruction word
module imem_line_buf
  import imem_fetch_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          nRst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] pc,
  output logic          hit,
  output logic [DW-1:0] rdata
);

  logic          buf_vld;
  logic [AW-1:0] buf_addr;
  logic [DW-1:0] buf_data;

  // Only reset invalidates the entry; a fill simply replaces it.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      buf_vld  <= 1'b0;
      buf_addr <= '0;
      buf_data <= '0;
    end else if (we) begin
      buf_vld  <= 1'b1;
      buf_addr <= waddr;
      buf_data <= wdata;
    end
  end

  assign hit   = buf_vld && (buf_addr == pc);
  assign rdata = buf_data;

endmodule

// File: rtl/imem_fetch_responder.sv
// rtl/imem_fetch_responder.sv - PC-fetch responder with req/ack memory port and line buffer
//
// Ports:
//   clk, nRst                   clock, async active-low reset
//   pc, flush, dec_stall        fetch-stage PC, redirect (useAlt), decode stall
//   hlt                         combinational hold to the fetch stage
//   mem_req, mem_addr           registered read request, address stable while requesting
//   mem_ack, mem_rdata          read data valid / data from instruction memory
//   instr, instr_valid          registered instruction to decode
module imem_fetch_responder
  import imem_fetch_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          nRst,
  input  logic [AW-1:0] pc,
  input  logic          flush,
  input  logic          dec_stall,
  output logic          hlt,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] instr,
  output logic          instr_valid
);

  fetch_state_t  state, state_nxt;
  logic          hit;
  logic [DW-1:0] buf_data;
  logic          issue;
  logic          buf_we;
  logic          done;

  imem_line_buf #(.AW(AW), .DW(DW)) u_buf (
    .clk   (clk),
    .nRst  (nRst),
    .we    (buf_we),
    .waddr (mem_addr),
    .wdata (mem_rdata),
    .pc    (pc),
    .hit   (hit),
    .rdata (buf_data)
  );

  // The fetch stage gives hlt priority over useAlt, so a redirect must never see hlt.
  assign hlt = !flush && (!hit || dec_stall);

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) state <= IDLE;
    else       state <= state_nxt;
  end

  // A request is never retracted: a redirect while waiting parks in DROP until the ack.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!flush && !hit) state_nxt = BUSY;
      BUSY:    if (mem_ack) state_nxt = IDLE;
               else if (flush) state_nxt = DROP;
      DROP:    if (mem_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    issue  = (state == IDLE) && !flush && !hit;
    buf_we = (state == BUSY) && mem_ack && !flush;
    done   = (state != IDLE) && mem_ack;
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else if (issue) begin
      mem_req  <= 1'b1;
      mem_addr <= pc;
    end else if (done) begin
      mem_req  <= 1'b0;
    end
  end

  // Decode output: flush kills validity but keeps the last word; stall freezes both.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      instr       <= '0;
      instr_valid <= 1'b0;
    end else if (flush) begin
      instr_valid <= 1'b0;
    end else if (!dec_stall) begin
      if (hit) begin
        instr       <= buf_data;
        instr_valid <= 1'b1;
      end else begin
        instr_valid <= 1'b0;
      end
    end
  end

endmodule
